poly_load_ctrl: RTL

- Host-side loader that sits directly upstream of the sparse poly_mult memory stage on the CW305.
- Assembles 16-byte host streams into 128-bit words and drives the downstream load interface (load, key, data) with the hold timing that stage needs.
- Write sessions fill POSITION_RAM (keys 0..WEIGHT-1) and RANDOM_BITS_MEM (keys WEIGHT..WEIGHT+RB_WORDS-1).
- Readback sessions sweep keys with all-zero data, capture the returned words and hand them back to the host.

---
 rtl/poly_load_pkg.sv | 30 +++
 rtl/poly_load_ctrl_if.sv | 54 +++++
 rtl/poly_load_ctrl_byte_packer.sv | 46 ++++
 rtl/poly_load_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/poly_load_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : poly_load_pkg
//  Description : Shared constants and FSM state encoding for the poly_mult
//                host-side loader (poly_load_ctrl and its byte packer).
//  Revision    : 1.0  initial release
// ============================================================================
package poly_load_pkg;

    // Default memory geometry of the downstream poly_mult stage
    localparam int DEF_WEIGHT     = 66;
    localparam int DEF_RB_WORDS   = 553;
    localparam int KEY_MAX        = DEF_WEIGHT + DEF_RB_WORDS;
    localparam int BYTES_PER_WORD = 16;
    localparam int WORD_W         = BYTES_PER_WORD * 8;

    localparam logic MODE_WRITE = 1'b0;
    localparam logic MODE_READ  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_GAP     = 3'd3,
        ST_PRESENT = 3'd4,
        ST_NEXT    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/poly_load_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : poly_load_ctrl_if
//  Description : Bundles the host session/byte/readback signals and the
//                downstream load bus of poly_load_ctrl.
//                slave  : view of the loader itself
//                master : view of the environment (host + downstream stage)
//  Revision    : 1.0  initial release
// ============================================================================
interface poly_load_ctrl_if #(
    parameter int KEY_W  = 10,
    parameter int DATA_W = 128
);
    // host session control
    logic              start_i;
    logic              mode_i;
    logic [KEY_W-1:0]  key_base_i;
    logic [KEY_W-1:0]  count_i;
    // host byte stream
    logic              byte_valid_i;
    logic [7:0]        byte_i;
    logic              byte_ready_o;
    // downstream load bus
    logic              load_o;
    logic [KEY_W-1:0]  key_o;
    logic [DATA_W-1:0] data_o;
    logic [DATA_W-1:0] rdata_i;
    logic              busy_i;
    // host readback
    logic              rvalid_o;
    logic [DATA_W-1:0] rdata_o;
    logic              rready_i;
    // status
    logic              done_o;
    logic              err_o;

    modport slave (
        input  start_i, mode_i, key_base_i, count_i,
        input  byte_valid_i, byte_i,
        input  rdata_i, busy_i, rready_i,
        output byte_ready_o, load_o, key_o, data_o,
        output rvalid_o, rdata_o, done_o, err_o
    );

    modport master (
        output start_i, mode_i, key_base_i, count_i,
        output byte_valid_i, byte_i,
        output rdata_i, busy_i, rready_i,
        input  byte_ready_o, load_o, key_o, data_o,
        input  rvalid_o, rdata_o, done_o, err_o
    );

endinterface
`default_nettype wire

// File: rtl/poly_load_ctrl_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer
//  Description : Assembles 16 host bytes into one little-endian 128-bit word
//                (first byte lands in bits [7:0]).
//  Ports       : clk, rst   clock / asynchronous active-high reset
//                clear      restart assembly, zero the word
//                push       accept byte_in this cycle
//                byte_in    host byte
//                word       assembled word
//                full       this push completes the word
//  Revision    : 1.0  initial release
// ============================================================================
module byte_packer
    import poly_load_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              clear,
    input  wire logic              push,
    input  wire logic [7:0]        byte_in,
    output logic      [WORD_W-1:0] word,
    output logic                   full
);

    logic [3:0] cnt;

    // Combinational so the controller can leave COLLECT on the edge that
    // stores the last byte.
    assign full = push && (cnt == 4'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            word <= '0;
        end else if (clear) begin
            cnt  <= '0;
            word <= '0;
        end else if (push) begin
            word[{cnt, 3'b000} +: 8] <= byte_in;
            cnt                      <= cnt + 4'd1;   // wraps to 0 after byte 15
        end
    end

endmodule
`default_nettype wire

// File: rtl/poly_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : poly_load_ctrl
//  Description : Host-side loader for the sparse poly_mult memory stage.
//                Write sessions pack 16 host bytes per word and strobe each
//                word into the downstream stage for HOLD cycles; readback
//                sessions strobe all-zero data, capture rdata_i one cycle
//                after the strobe and present it to the host.
//  Ports       : clk   system clock
//                rst   asynchronous active-high reset
//                bus   poly_load_ctrl_if.slave (session control, host
//                      bytes, downstream load bus, readback, done/err)
//  Revision    : 1.0  initial release
// ============================================================================
module poly_load_ctrl
    import poly_load_pkg::*;
#(
    parameter int WEIGHT   = DEF_WEIGHT,
    parameter int RB_WORDS = DEF_RB_WORDS,
    parameter int KEY_W    = 10,
    parameter int HOLD     = 3,
    parameter int DATA_W   = WORD_W
)(
    input  wire logic         clk,
    input  wire logic         rst,
    poly_load_ctrl_if.slave   bus
);

    localparam int KEY_LIMIT = WEIGHT + RB_WORDS;

    state_t              state;
    state_t              next_state;

    logic                mode;
    logic [KEY_W-1:0]    key;
    logic [KEY_W-1:0]    remaining;
    logic [2:0]          hold_cnt;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    logic [DATA_W-1:0]   word;
    logic                full;
    logic                push;
    logic                clear;
    logic                byte_ready;
    logic                start_ok;
    logic                start_bad;
    logic [KEY_W:0]      range_sum;
    logic                zero_word;
    logic                hold_last;
    logic                last_word;

    logic                load;
    logic [DATA_W-1:0]   data;
    logic                rvalid;
    logic                done;

    // ------------------------------------------------------------------
    // Byte assembly
    // ------------------------------------------------------------------
    assign byte_ready = (state == ST_COLLECT);
    assign push       = bus.byte_valid_i && byte_ready;

    byte_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .push    (push),
        .byte_in (bus.byte_i),
        .word    (word),
        .full    (full)
    );

    // ------------------------------------------------------------------
    // Session qualification: the sum is one bit wider than the key so a
    // range that would wrap the key counter is rejected, never issued.
    // ------------------------------------------------------------------
    assign start_ok  = (state == ST_IDLE) && bus.start_i;
    assign range_sum = {1'b0, bus.key_base_i} + {1'b0, bus.count_i};
    assign start_bad = (bus.count_i == '0) || (range_sum > (KEY_W + 1)'(KEY_LIMIT));

    // Downstream treats zero data as a read, so an all-zero write word is
    // suppressed and flagged instead of strobed.
    assign zero_word = (mode == MODE_WRITE) && (word == '0);
    assign hold_last = (hold_cnt == 3'(HOLD - 1));
    assign last_word = (remaining == KEY_W'(1));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        load       = 1'b0;
        data       = '0;
        rvalid     = 1'b0;
        done       = 1'b0;
        clear      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    if (start_bad) begin
                        done = 1'b1;
                    end else begin
                        clear      = 1'b1;
                        next_state = bus.mode_i ? ST_ISSUE : ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                if (full) begin
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                load = !zero_word;
                if (mode == MODE_WRITE) begin
                    data = word;
                end
                if (hold_last) begin
                    next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                next_state = (mode == MODE_READ) ? ST_PRESENT : ST_NEXT;
            end
            ST_PRESENT: begin
                rvalid = 1'b1;
                if (bus.rready_i) begin
                    next_state = ST_NEXT;
                end
            end
            ST_NEXT: begin
                clear = 1'b1;
                if (last_word) begin
                    done       = 1'b1;
                    next_state = ST_IDLE;
                end else begin
                    next_state = (mode == MODE_READ) ? ST_ISSUE : ST_COLLECT;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Session datapath: mode, key, remaining count, hold timer, readback
    // capture and the sticky error flag.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode      <= MODE_WRITE;
            key       <= '0;
            remaining <= '0;
            hold_cnt  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (start_ok) begin
                if (start_bad) begin
                    err_q <= 1'b1;
                end else begin
                    err_q     <= 1'b0;
                    mode      <= bus.mode_i;
                    key       <= bus.key_base_i;
                    remaining <= bus.count_i;
                end
            end
            if (state == ST_ISSUE) begin
                hold_cnt <= hold_last ? 3'd0 : hold_cnt + 3'd1;
                if (zero_word) begin
                    err_q <= 1'b1;
                end
            end
            // Downstream answers one cycle after the strobe window closes
            if ((state == ST_GAP) && (mode == MODE_READ)) begin
                rdata_q <= bus.rdata_i;
            end
            if (state == ST_NEXT) begin
                key       <= key + KEY_W'(1);
                remaining <= remaining - KEY_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign bus.byte_ready_o = byte_ready;
    assign bus.load_o       = load;
    assign bus.key_o        = key;
    assign bus.data_o       = data;
    assign bus.rvalid_o     = rvalid;
    assign bus.rdata_o      = rdata_q;
    assign bus.done_o       = done;
    assign bus.err_o        = err_q;

endmodule
`default_nettype wire
